// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared types and constants for the nibble-serial subtractor and its ALU users.
package nibble_serial_subtractor_pkg;

   // Width of one subtract slice; the datapath processes one nibble per cycle.
   localparam int NIBBLE_W = 4;

   // Bit positions when the result flags are packed into an ALU flag vector.
   localparam int FLAG_ZERO = 0;
   localparam int FLAG_OVF  = 1;
   localparam int FLAG_LTS  = 2;
   localparam int FLAG_BOR  = 3;
   localparam int FLAG_W    = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Result flags as a packed struct, bit order matching the FLAG_* indices.
   typedef struct packed {
      logic bor;
      logic lts;
      logic ovf;
      logic zero;
   } sub_flags_t;

   // Signed overflow of a - b: operands differ in sign and the result sign
   // differs from the minuend.
   function automatic logic sub_ovf(input logic a_msb, input logic b_msb,
                                    input logic d_msb);
      return (a_msb ^ b_msb) & (a_msb ^ d_msb);
   endfunction

endpackage

// File: rtl/ripple_borrow_subtractor.sv
// Combinational 4-bit ripple-borrow subtractor: d = a - b - bin, bout = borrow out.
module ripple_borrow_subtractor
   import nibble_serial_subtractor_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                bin,
   output logic [NIBBLE_W-1:0] d,
   output logic                bout
);

   logic [NIBBLE_W:0] bw;

   assign bw[0] = bin;

   // One full subtractor per bit, borrow rippling upward.
   for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
      assign d[i]    = a[i] ^ b[i] ^ bw[i];
      assign bw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
   end

   assign bout = bw[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor: A - B - Bin, one nibble per cycle, LSB first,
// with a registered borrow between nibbles and zero/overflow/less-than flags.
// WIDTH must be a multiple of 4 and at least 8.
module nibble_serial_subtractor
   import nibble_serial_subtractor_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] Diff,
   output logic             Bor,
   output logic             Zero,
   output logic             Ovf,
   output logic             Lts
);

   localparam int NIBBLES = WIDTH / NIBBLE_W;
   localparam int IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

   state_t           state;
   logic [IW-1:0]    idx;
   logic             brw;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;

   logic [IW+1:0]         base;
   logic [NIBBLE_W-1:0]   sl_a;
   logic [NIBBLE_W-1:0]   sl_b;
   logic [NIBBLE_W-1:0]   sl_d;
   logic                  sl_bout;
   logic [WIDTH-1:0]      diff_full;
   logic                  last;
   sub_flags_t            flags_n;

   // Nibble offset of the current slice (idx * 4).
   assign base = {idx, 2'b00};
   assign sl_a = a_r[base +: NIBBLE_W];
   assign sl_b = b_r[base +: NIBBLE_W];
   assign last = (idx == LAST);

   ripple_borrow_subtractor u_slice (
      .a    (sl_a),
      .b    (sl_b),
      .bin  (brw),
      .d    (sl_d),
      .bout (sl_bout)
   );

   // Difference as it will look after this cycle's nibble is written; on the
   // last nibble this is the completed result used for the flags.
   always_comb begin
      diff_full = Diff;
      diff_full[base +: NIBBLE_W] = sl_d;
   end

   // Final flags derived from the completed difference and operand signs.
   always_comb begin
      flags_n      = '0;
      flags_n.bor  = sl_bout;
      flags_n.zero = (diff_full == '0);
      flags_n.ovf  = sub_ovf(a_r[WIDTH-1], b_r[WIDTH-1], diff_full[WIDTH-1]);
      flags_n.lts  = diff_full[WIDTH-1] ^ flags_n.ovf;
   end

   // Operands are accepted only in IDLE and never while reset is asserted.
   assign start_ready = (state == IDLE) && !rst;

   // Control FSM, nibble counter, borrow chain and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         brw       <= 1'b0;
         a_r       <= '0;
         b_r       <= '0;
         Diff      <= '0;
         Bor       <= 1'b0;
         Zero      <= 1'b0;
         Ovf       <= 1'b0;
         Lts       <= 1'b0;
         res_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_valid) begin
                  a_r   <= A;
                  b_r   <= B;
                  brw   <= Bin;
                  idx   <= '0;
                  Diff  <= '0;
                  Bor   <= 1'b0;
                  Zero  <= 1'b0;
                  Ovf   <= 1'b0;
                  Lts   <= 1'b0;
                  state <= BUSY;
               end
            end
            BUSY: begin
               Diff <= diff_full;
               brw  <= sl_bout;
               idx  <= idx + 1'b1;
               if (last) begin
                  Bor       <= flags_n.bor;
                  Zero      <= flags_n.zero;
                  Ovf       <= flags_n.ovf;
                  Lts       <= flags_n.lts;
                  res_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               res_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed self-checking bench for nibble_serial_subtractor (WIDTH=32).
module tb_nibble_serial_subtractor;

   localparam int WIDTH   = 32;
   localparam int NIBBLES = WIDTH / 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start_valid = 1'b0;
   logic             start_ready;
   logic [WIDTH-1:0] A = '0;
   logic [WIDTH-1:0] B = '0;
   logic             Bin = 1'b0;
   logic             res_valid;
   logic             res_ready = 1'b0;
   logic [WIDTH-1:0] Diff;
   logic             Bor, Zero, Ovf, Lts;

   int checks = 0;
   int errors = 0;

   nibble_serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .A           (A),
      .B           (B),
      .Bin         (Bin),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .Diff        (Diff),
      .Bor         (Bor),
      .Zero        (Zero),
      .Ovf         (Ovf),
      .Lts         (Lts)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present operands, wait (bounded) for start_ready, hold through the accept edge.
   task automatic start_op(input string tag, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic bin);
      int n = 0;
      while (!start_ready && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_ready"}, start_ready, 1'b1);
      A = a; B = b; Bin = bin;
      start_valid = 1'b1;
      tick();
      start_valid = 1'b0;
   endtask

   // Count edges after the accept edge until res_valid rises (bounded).
   task automatic wait_done(input string tag);
      int lat = 0;
      while (!res_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk({tag, "_lat"}, lat, NIBBLES);
   endtask

   task automatic chk_res(input string tag, input logic [WIDTH-1:0] d, input logic bor,
                          input logic z, input logic ovf, input logic lts);
      chk({tag, "_diff"}, Diff, d);
      chk({tag, "_flags"}, {Bor, Zero, Ovf, Lts}, {bor, z, ovf, lts});
   endtask

   task automatic release_res(input string tag);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk({tag, "_drop"}, res_valid, 1'b0);
   endtask

   task automatic op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                     input logic bin, input logic [WIDTH-1:0] d, input logic bor,
                     input logic z, input logic ovf, input logic lts);
      start_op(tag, a, b, bin);
      wait_done(tag);
      chk_res(tag, d, bor, z, ovf, lts);
      release_res(tag);
   endtask

   initial begin
      // Reset with start_valid held high: reset must win.
      A = 32'h5; B = 32'h3; start_valid = 1'b1;
      tick(); tick(); tick();
      chk("rst_start_ready", start_ready, 1'b0);
      chk("rst_res_valid", res_valid, 1'b0);
      chk_res("rst", '0, 1'b0, 1'b0, 1'b0, 1'b0);
      start_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("post_rst_ready", start_ready, 1'b1);
      for (int i = 0; i < 12; i++) tick();
      chk("post_rst_no_valid", res_valid, 1'b0);

      op("basic",  32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 0, 0, 0, 0);
      op("uflow",  32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1, 0, 0, 1);
      op("sovf",   32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 0, 0, 1, 1);
      op("ripple", 32'h1000_0000, 32'h0000_0000, 1'b1, 32'h0FFF_FFFF, 0, 0, 0, 0);
      op("equal",  32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 0, 1, 0, 0);
      op("eq_bin", 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1, 32'hFFFF_FFFF, 1, 0, 0, 1);
      op("pos_neg",32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1, 0, 1, 0);

      // Backpressure: result held for 5 cycles, stray start ignored.
      start_op("bp", 32'h0000_0007, 32'h0000_0002, 1'b0);
      wait_done("bp");
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            A = 32'hDEAD_BEEF; B = 32'h1; start_valid = 1'b1;
         end
         tick();
         start_valid = 1'b0;
         chk("bp_hold_valid", res_valid, 1'b1);
         chk("bp_hold_ready", start_ready, 1'b0);
         chk_res("bp_hold", 32'h5, 0, 0, 0, 0);
      end
      release_res("bp");
      chk("bp_idle_ready", start_ready, 1'b1);
      chk("bp_kept_diff", Diff, 32'h5);
      op("bp_next", 32'h0000_0064, 32'h0000_0001, 1'b0, 32'h0000_0063, 0, 0, 0, 0);

      // Reset during the 4th BUSY cycle aborts the operation.
      start_op("abort", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      chk("abort_ready_in_rst", start_ready, 1'b0);
      chk("abort_valid", res_valid, 1'b0);
      chk_res("abort", '0, 0, 0, 0, 0);
      rst = 1'b0;
      #1;
      chk("abort_idle_ready", start_ready, 1'b1);
      for (int i = 0; i < 10; i++) tick();
      chk("abort_no_pulse", res_valid, 1'b0);
      op("after_abort", 32'h0000_0009, 32'h0000_0004, 1'b0, 32'h0000_0005, 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/nibble_serial_subtractor.md
Name: nibble_serial_subtractor

Overview:
- Multi-cycle WIDTH-bit subtractor computing A - B - Bin with one 4-bit ripple-borrow slice, one nibble per cycle, LSB nibble first.
- A registered borrow carries between nibbles.
- Sits between operand issue and compare/branch logic; the ALU uses it for SUB, SLT/SLTU and branch compares when area beats latency.
- Valid/ready handshake on both sides; also produces zero, signed-overflow and signed/unsigned less-than flags.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of 4 and >= 8.
- NIBBLES (localparam), WIDTH/4, number of BUSY cycles.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start_valid  input  1  operands valid.
- start_ready  output  1  block can accept operands.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- Bin  input  1  borrow-in.
- res_valid  output  1  result valid.
- res_ready  input  1  consumer accepts result.
- Diff  output  WIDTH  A - B - Bin, modulo 2^WIDTH.
- Bor  output  1  final borrow-out (unsigned A < B + Bin).
- Zero  output  1  Diff == 0.
- Ovf  output  1  signed overflow.
- Lts  output  1  signed less-than, computed as Diff[MSB] ^ Ovf.

Behaviour:
- Reset (rst=1 at a rising edge):
  - State goes to IDLE.
  - idx, borrow register, operand registers, Diff, Bor, Zero, Ovf and Lts all go to 0.
  - res_valid=0.
  - start_ready=0 while rst is high, and 1 from the first cycle after reset.
- States: IDLE, BUSY, DONE. start_ready = (state==IDLE) && !rst.
- IDLE:
  - On start_valid && start_ready: latch A, B; borrow register <= Bin; idx <= 0; clear Diff, Bor and all flags; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY, each cycle:
  - The slice is fed A_r[4*idx+:4], B_r[4*idx+:4] and the borrow register.
  - Diff[4*idx+:4] <= slice difference; borrow register <= slice borrow-out; idx <= idx+1.
  - When idx == NIBBLES-1:
    - Bor <= slice borrow-out.
    - Zero, Ovf and Lts are registered from the completed Diff, A_r[MSB] and B_r[MSB].
    - Ovf = (A_r[MSB]^B_r[MSB]) & (A_r[MSB]^Diff[MSB]).
    - Go to DONE.
  - start_valid is ignored.
- DONE:
  - res_valid=1; Diff, Bor and flags held stable.
  - On res_ready go to IDLE; res_valid drops the next cycle.
  - start_ready=0, so no start is accepted in the handoff cycle.
- Latency: accept at edge k → res_valid high after edge k+NIBBLES (8 cycles for WIDTH=32).
- Throughput: one operation per NIBBLES+2 cycles minimum.
- Outputs between operations: after a result handoff, Diff and flags keep their last values until the next accept. During BUSY they are partial and not qualified.
- idx wrap: idx is only compared against NIBBLES-1 and is reset on accept; it never wraps while in BUSY.
- Reset mid-operation (BUSY or DONE): abort, discard the partial result, apply reset values; no res_valid pulse for the aborted op.
- start_valid and rst high together: rst wins; nothing is accepted.
- Bin=1 with A=B gives Diff=all-ones and Bor=1.

Decomposition:
- Shared package:
  - State enum (IDLE/BUSY/DONE).
  - NIBBLE_W=4 constant.
  - Flag-bit index constants (ZERO, OVF, LTS, BOR), for ALU flag vectors.
- One sub-module instance: the existing 4-bit ripple_borrow_subtractor as the combinational slice.
- FSM, counter and registers are inline in nibble_serial_subtractor.

Test Plan:
- Basic subtract: A=0x00000005, B=0x00000003, Bin=0 → Diff=0x00000002, Bor=0, Zero=0, Ovf=0, Lts=0; res_valid rises exactly 8 cycles after the accept edge.
- Unsigned underflow: A=0x00000000, B=0x00000001 → Diff=0xFFFFFFFF, Bor=1, Lts=1, Ovf=0.
- Signed overflow: A=0x80000000, B=0x00000001 → Diff=0x7FFFFFFF, Ovf=1, Lts=1, Bor=0.
- Full borrow ripple: A=0x10000000, B=0, Bin=1 → Diff=0x0FFFFFFF, Bor=0.
- Equality: A=B=0x12345678, Bin=0 → Diff=0, Zero=1.
- Backpressure: hold res_ready=0 for 5 cycles in DONE → Diff, flags and res_valid=1 all stable; start_ready=0; a pulsed start_valid is ignored. Then res_ready=1 → IDLE; the next op is accepted and completes correctly.
- Reset mid-BUSY: assert rst at the 4th BUSY cycle → next cycle IDLE with all outputs 0 and no res_valid; a following op A=9, B=4 gives Diff=5.
